// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

  localparam int MDU_WIDTH     = 32;
  localparam int MDU_DIV_ITERS = MDU_WIDTH;

  function automatic logic op_is_div(input mdu_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring radix-2 divider on operand magnitudes, one quotient bit per cycle.
// Results are presented from the combinational next step so the final bit is usable in the last cycle.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_DIV_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             neg_q,
  input  logic             neg_r,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int IW = $clog2(WIDTH + 1);

  logic [IW-1:0]     iter_q;
  logic [2*WIDTH:0]  prem_p0;
  logic [2*WIDTH:0]  prem_next;
  logic [2*WIDTH:0]  shifted;
  logic [WIDTH+1:0]  trial;
  logic [WIDTH-1:0]  dvs_p0;
  logic              neg_q_p0;
  logic              neg_r_p0;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_q <= '0;
    end else if (flush) begin
      iter_q <= '0;
    end else if (start) begin
      iter_q <= IW'(WIDTH);
    end else if (iter_q != '0) begin
      iter_q <= iter_q - 1'b1;
    end
  end

  // stage p0: partial remainder {rem, quotient bits} plus latched divisor and fixup flags
  always_ff @(posedge clk) begin
    if (start && !flush) begin
      prem_p0  <= {{(WIDTH+1){1'b0}}, dividend};
      dvs_p0   <= divisor;
      neg_q_p0 <= neg_q;
      neg_r_p0 <= neg_r;
    end else if (iter_q != '0) begin
      prem_p0  <= prem_next;
    end
  end

  always_comb begin
    shifted   = prem_p0 << 1;
    trial     = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, dvs_p0};
    prem_next = shifted;
    if (!trial[WIDTH+1]) begin
      prem_next[2*WIDTH:WIDTH] = trial[WIDTH:0];
      prem_next[0]             = 1'b1;
    end
  end

  assign quotient  = apply_sign(prem_next[WIDTH-1:0], neg_q_p0);
  assign remainder = apply_sign(prem_next[2*WIDTH-1:WIDTH], neg_r_p0);

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the execute stage with hazard-unit handshake.
// The FSM, multiply path and HI/LO registers live here; the divide core is mdu_divider.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = MDU_DIV_ITERS,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  mdu_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             stall_i,
  output logic             e_wait,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  mdu_state_t          state_q;
  mdu_state_t          state_d;
  logic [CW-1:0]       count_q;
  logic                issue;
  logic                load_res;
  logic                is_div_in;
  logic                sign_a;
  logic                sign_b;
  logic [WIDTH-1:0]    mag_a;
  logic [WIDTH-1:0]    mag_b;
  logic [WIDTH-1:0]    mag_a_p0;
  logic [WIDTH-1:0]    mag_b_p0;
  logic                div_p0;
  logic                neg_prod_p0;
  logic [2*WIDTH-1:0]  prod_mag;
  logic [2*WIDTH-1:0]  prod_p1;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    div_quo;
  logic [WIDTH-1:0]    div_rem;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    lo_q;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic neg);
    return neg ? -v : v;
  endfunction

  assign is_div_in = op_is_div(op_i);
  assign sign_a    = op_is_signed(op_i) & a_i[WIDTH-1];
  assign sign_b    = op_is_signed(op_i) & b_i[WIDTH-1];
  assign mag_a     = apply_sign(a_i, sign_a);
  assign mag_b     = apply_sign(b_i, sign_b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (valid_i)        state_d = ST_BUSY;
        ST_BUSY: if (count_q == '0)  state_d = ST_DONE;
        ST_DONE: if (!stall_i)       state_d = ST_IDLE;
        default:                     state_d = ST_IDLE;
      endcase
    end
  end

  // e_wait is masked by reset so the hazard unit sees no request while the unit is held
  always_comb begin
    e_wait   = reset & valid_i & (state_q != ST_DONE);
    done_o   = (state_q == ST_DONE);
    issue    = (state_q == ST_IDLE) & valid_i & ~flush_i;
    load_res = (state_q == ST_BUSY) & (count_q == '0) & ~flush_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (issue) begin
      count_q <= is_div_in ? CW'(WIDTH - 1) : CW'(MUL_LAT - 1);
    end else if ((state_q == ST_BUSY) && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // stage p0: operand magnitudes and sign fixup captured at issue
  always_ff @(posedge clk) begin
    if (issue) begin
      mag_a_p0    <= mag_a;
      mag_b_p0    <= mag_b;
      div_p0      <= is_div_in;
      neg_prod_p0 <= sign_a ^ sign_b;
    end
  end

  assign prod_mag = {{WIDTH{1'b0}}, mag_a_p0} * {{WIDTH{1'b0}}, mag_b_p0};

  // stage p1: product register, only when the latency budget leaves room for it
  generate
    if (MUL_LAT > 1) begin : g_mul_reg
      always_ff @(posedge clk) begin
        prod_p1 <= prod_mag;
      end
    end else begin : g_mul_comb
      assign prod_p1 = prod_mag;
    end
  endgenerate

  assign prod_fix = apply_sign_wide(prod_p1, neg_prod_p0);

  // A zero divisor keeps the all-ones quotient unsigned-looking for DIV as well.
  mdu_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (issue & is_div_in),
    .flush     (flush_i),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .neg_q     ((sign_a ^ sign_b) & (|b_i)),
    .neg_r     (sign_a),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (load_res) begin
      if (div_p0) begin
        hi_q <= div_rem;
        lo_q <= div_quo;
      end else begin
        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
        lo_q <= prod_fix[WIDTH-1:0];
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  a_valid_held_in_busy: assert property (@(posedge clk) disable iff (!reset)
    ((state_q == ST_BUSY) && !flush_i) |-> valid_i);

endmodule
